// File: rtl/mydivider_pkg.sv
// Shared definitions for the programmable clock divider and the rate generators built on it.
// Holds the state encoding, the divisor clamp and the high/low split of a period.
package mydivider_pkg;

   typedef enum logic [0:0] {
      StStop = 1'b0,
      StRun  = 1'b1
   } state_e;

   localparam int unsigned MinDiv = 2;

   // Divisors 0 and 1 cannot form a period with both a high and a low phase.
   function automatic logic [31:0] clamp_div(input logic [31:0] div);
      return (div < MinDiv) ? MinDiv : div;
   endfunction

   // Odd ratios put the extra cycle in the high phase.
   function automatic logic [31:0] high_cycles(input logic [31:0] n);
      return n - (n >> 1);
   endfunction

   function automatic logic [31:0] low_cycles(input logic [31:0] n);
      return n >> 1;
   endfunction

endpackage

// File: rtl/mydivider_phase_cnt.sv
// Modulo-N phase counter with terminal-count flag; exposes its next value so the
// owner can register outputs that line up with the counter.
module mydivider_phase_cnt #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] mod_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic [WIDTH-1:0] cnt_next_o,
   output logic             tc_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   assign tc_o = (cnt_q == (mod_i - WIDTH'(1)));

   always_comb begin
      cnt_d = cnt_q + WIDTH'(1);
      if (clear_i || tc_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o      = cnt_q;
   assign cnt_next_o = cnt_d;

endmodule

// File: rtl/mydivider_n.sv
// Programmable glitch-free integer clock divider with a fast-clock tick enable.
// Divisor and run/stop changes land only on period boundaries.
module mydivider_n
   import mydivider_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned DEFAULT_DIV = 2
) (
   input  logic             CLK_i,
   input  logic             RST_i,
   input  logic             EN_i,
   input  logic             LOAD_i,
   input  logic [WIDTH-1:0] DIV_i,
   output logic             CLK_o,
   output logic             TICK_o,
   output logic             BUSY_o,
   output logic [WIDTH-1:0] ACTIVE_DIV_o
);

   localparam logic [WIDTH-1:0] ResetDiv = WIDTH'(clamp_div(32'(DEFAULT_DIV)));

   state_e           state_q;
   logic [WIDTH-1:0] n_q;
   logic [WIDTH-1:0] p_q;
   logic             pv_q;
   logic             clk_q;
   logic             tick_q;

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] cnt_next;
   logic             tc;
   logic [WIDTH-1:0] div_req;
   logic [WIDTH-1:0] n_next;
   logic [WIDTH-1:0] high_next;
   logic             boundary;
   logic             run_next;

   // Held at zero outside RUN so the first enabled edge starts phase 0.
   mydivider_phase_cnt #(
      .WIDTH (WIDTH)
   ) u_phase_cnt (
      .clk_i      (CLK_i),
      .rst_i      (RST_i),
      .clear_i    (state_q != StRun),
      .mod_i      (n_q),
      .cnt_o      (cnt),
      .cnt_next_o (cnt_next),
      .tc_o       (tc)
   );

   always_comb begin
      div_req  = WIDTH'(clamp_div(32'(DIV_i)));
      boundary = (state_q == StRun) && tc;
      run_next = (state_q == StRun) ? (!boundary || EN_i) : EN_i;
      n_next   = n_q;
      if (state_q == StStop) begin
         if (LOAD_i) begin
            n_next = div_req;
         end
      end else if (boundary) begin
         // A load on the boundary edge bypasses the pending register.
         if (LOAD_i) begin
            n_next = div_req;
         end else if (pv_q) begin
            n_next = p_q;
         end
      end
      high_next = WIDTH'(high_cycles(32'(n_next)));
   end

   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         state_q <= StStop;
         n_q     <= ResetDiv;
         p_q     <= ResetDiv;
         pv_q    <= 1'b0;
         clk_q   <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= run_next ? StRun : StStop;
         n_q     <= n_next;
         if ((state_q == StRun) && !boundary && LOAD_i) begin
            p_q  <= div_req;
            pv_q <= 1'b1;
         end else if ((state_q == StStop) || boundary) begin
            pv_q <= 1'b0;
         end
         clk_q  <= run_next && (cnt_next < high_next);
         tick_q <= run_next && (cnt_next == '0);
      end
   end

   assign CLK_o        = clk_q;
   assign TICK_o       = tick_q;
   assign BUSY_o       = (state_q == StRun);
   assign ACTIVE_DIV_o = n_q;

endmodule

// File: tb/tb_mydivider_n.sv
// Directed bench for mydivider_n: hand-computed expectations queued per edge,
// checked by an independent monitor on the falling edge.
module tb_mydivider_n;

   logic       clk;
   logic       rst;
   logic       en;
   logic       load;
   logic [7:0] div;
   logic       clk_out;
   logic       tick;
   logic       busy;
   logic [7:0] active_div;

   typedef struct {
      logic       c;
      logic       t;
      logic       b;
      logic [7:0] d;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   mydivider_n #(
      .WIDTH       (8),
      .DEFAULT_DIV (2)
   ) dut (
      .CLK_i        (clk),
      .RST_i        (rst),
      .EN_i         (en),
      .LOAD_i       (load),
      .DIV_i        (div),
      .CLK_o        (clk_out),
      .TICK_o       (tick),
      .BUSY_o       (busy),
      .ACTIVE_DIV_o (active_div)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         total++;
         if (clk_out !== e.c || tick !== e.t || busy !== e.b || active_div !== e.d) begin
            bad++;
            $display("FAIL %s: got clk=%b tick=%b busy=%b div=%0d, want clk=%b tick=%b busy=%b div=%0d",
                     e.name, clk_out, tick, busy, active_div, e.c, e.t, e.b, e.d);
         end
      end
   end

   task automatic step(input logic r, input logic e, input logic l, input logic [7:0] dv,
                       input logic c, input logic t, input logic b, input logic [7:0] ad,
                       input string name);
      exp_t x;
      rst  = r;
      en   = e;
      load = l;
      div  = dv;
      x.c = c; x.t = t; x.b = b; x.d = ad; x.name = name;
      exp_q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   // One edge per character; EN held, no loads.
   task automatic steps(input logic e, input string cs, input string ts, input string bs,
                        input logic [7:0] ad, input string name);
      for (int i = 0; i < cs.len(); i++) begin
         step(1'b0, e, 1'b0, 8'd0, cs[i] == "1", ts[i] == "1", bs[i] == "1", ad,
              $sformatf("%s[%0d]", name, i));
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; load = 1'b0; div = 8'd0;
      #1;
      // Reset and default divide-by-2
      step(1, 0, 0, 0, 0, 0, 0, 2, "reset0");
      step(1, 0, 0, 0, 0, 0, 0, 2, "reset1");
      steps(1, "101010", "101010", "111111", 2, "div2");
      steps(0, "0", "0", "0", 2, "div2_stop");

      // Load 5 in STOP, then run
      step(0, 0, 1, 5, 0, 0, 0, 5, "load5_stop");
      steps(1, "1110011100", "1000010000", "1111111111", 5, "div5");
      steps(0, "0", "0", "0", 5, "div5_stop");

      // N=4, loads of 7 then 3 mid-period; only 3 takes effect
      step(0, 0, 1, 4, 0, 0, 0, 4, "load4_stop");
      steps(1, "11", "10", "11", 4, "div4");
      step(0, 1, 1, 7, 0, 0, 1, 4, "load7_cnt1");
      step(0, 1, 1, 3, 0, 0, 1, 4, "load3_cnt2");
      steps(1, "110110", "100100", "111111", 3, "div3");
      steps(0, "0", "0", "0", 3, "div3_stop");

      // N=6, drop EN at cnt=1: full period then stop
      step(0, 0, 1, 6, 0, 0, 0, 6, "load6_stop");
      steps(1, "11", "10", "11", 6, "div6");
      steps(0, "10000", "00000", "11110", 6, "div6_drain");
      steps(0, "0", "0", "0", 6, "div6_idle");

      // EN glitch inside one period has no effect
      steps(1, "11", "10", "11", 6, "glitch_a");
      step(0, 0, 0, 0, 1, 0, 1, 6, "glitch_off0");
      step(0, 1, 0, 0, 0, 0, 1, 6, "glitch_on0");
      step(0, 0, 0, 0, 0, 0, 1, 6, "glitch_off1");
      step(0, 1, 0, 0, 0, 0, 1, 6, "glitch_on1");
      steps(1, "111000", "100000", "111111", 6, "glitch_b");
      steps(0, "0", "0", "0", 6, "glitch_stop");

      // Clamp of 0 and 1, then load on a boundary edge
      step(0, 0, 1, 0, 0, 0, 0, 2, "clamp0");
      step(0, 0, 1, 9, 0, 0, 0, 9, "load9_stop");
      step(0, 0, 1, 1, 0, 0, 0, 2, "clamp1");
      steps(1, "10", "10", "11", 2, "pre9");
      step(0, 1, 1, 9, 1, 1, 1, 9, "load9_boundary");
      steps(0, "11110000", "00000000", "11111111", 9, "div9");
      steps(0, "0", "0", "0", 9, "div9_stop");

      // Reset mid-period at cnt=3 of N=8, with EN and LOAD also asserted
      step(0, 0, 1, 8, 0, 0, 0, 8, "load8_stop");
      steps(1, "1111", "1000", "1111", 8, "div8");
      step(1, 1, 1, 5, 0, 0, 0, 2, "rst_mid");
      steps(1, "101", "101", "111", 2, "after_rst");
      steps(0, "00", "00", "10", 2, "after_rst_stop");

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
